// File: rtl/async_fifo_pkg.sv
// ---------------------------------------------------------------------------
// async_fifo_pkg
// Shared definitions for the read- and write-side controllers of the
// asynchronous FIFO.
//
// Contents:
//   GRAY_MAX_W  widest pointer either controller may use
//   ptr_word_t  pointer-sized word at the widest width
//   bin2gray    binary -> Gray conversion
//   gray2bin    Gray -> binary conversion
// ---------------------------------------------------------------------------
package async_fifo_pkg;

  // Pointers narrower than this are zero-extended before conversion.
  // The top bit of a zero-extended Gray word equals the top bit of the
  // narrow Gray word, so truncating the result back is exact.
  localparam int GRAY_MAX_W = 32;

  typedef logic [GRAY_MAX_W-1:0] ptr_word_t;

  // Adjacent binary values map to Gray codes that differ in one bit, which
  // is what makes the pointer safe to resynchronise into the other domain.
  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Inverse conversion: each binary bit is the XOR of all Gray bits at or
  // above its position.
  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin = '0;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/async_fifo_rd_obuf.sv
// ---------------------------------------------------------------------------
// async_fifo_rd_obuf
// Two-entry first-word-fall-through output buffer on the read side of the
// asynchronous FIFO. Words arrive from the RAM one cycle after each read
// and leave in strict arrival order through the head slot.
//
// Ports:
//   RD_CLK     in   read-domain clock, rising edge
//   RD_RST     in   synchronous active-high reset, clears data and occupancy
//   push       in   a RAM word is present on push_data this cycle
//   push_data  in   C_WIDTH  word to append at the tail
//   take       in   consumer removes the head word this cycle
//   head_data  out  C_WIDTH  oldest buffered word (held when empty)
//   occ        out  2        number of buffered words, 0..2
// ---------------------------------------------------------------------------
module async_fifo_rd_obuf
  import async_fifo_pkg::*;
#(
  parameter int C_WIDTH = 32
) (
  input  logic               RD_CLK,
  input  logic               RD_RST,
  input  logic               push,
  input  logic [C_WIDTH-1:0] push_data,
  input  logic               take,
  output logic [C_WIDTH-1:0] head_data,
  output logic [1:0]         occ
);

  logic [C_WIDTH-1:0] rHead;
  logic [C_WIDTH-1:0] rTail;
  logic [1:0]         rOcc;
  logic               wTakeEff;
  logic [1:0]         wAfterTake;

  // A take against an empty buffer is meaningless, so it is dropped here
  // even if the caller forgot to qualify it.
  assign wTakeEff   = take & (rOcc != 2'd0);

  // Occupancy once this cycle's take has been applied; this is the slot an
  // arriving word lands in (0 = head, 1 = tail). The controller never
  // pushes into a full buffer, so 2 is never the landing slot.
  assign wAfterTake = rOcc - {1'b0, wTakeEff};

  // Slot update. When the head is taken with both slots full, the tail
  // word moves up; any arrival in that cycle then lands in the tail. The
  // head is never cleared on a take, so it keeps its last value while the
  // buffer is empty.
  always_ff @(posedge RD_CLK) begin
    if (RD_RST) begin
      rHead <= '0;
      rTail <= '0;
      rOcc  <= 2'd0;
    end else begin
      if (wTakeEff && (rOcc == 2'd2)) begin
        rHead <= rTail;
      end else if (push && (wAfterTake == 2'd0)) begin
        rHead <= push_data;
      end
      if (push && (wAfterTake == 2'd1)) begin
        rTail <= push_data;
      end
      rOcc <= wAfterTake + {1'b0, push};
    end
  end

  assign head_data = rHead;
  assign occ       = rOcc;

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// async_fifo_rd_ctrl
// Read-side controller of the asynchronous FIFO. Owns the binary read
// counter, publishes it in Gray code to the full/empty comparator together
// with the read-request strobe, issues RAM reads and hands the returned
// words to the consumer through a 2-entry FWFT buffer.
//
// Ports:
//   RD_CLK         in   read-domain clock, rising edge
//   RD_RST         in   synchronous active-high reset
//   RD_EMPTY       in   EMPTY flag from the comparator
//   RD_VALID       out  read request to the comparator
//   RD_PTR         out  C_DEPTH_BITS  Gray code of the read counter
//   RD_PTR_P1      out  C_DEPTH_BITS  Gray code of the read counter + 1
//   RAM_RD_EN      out  RAM read enable
//   RAM_RD_ADDR    out  C_DEPTH_BITS  binary RAM read address
//   RAM_RD_DATA    in   C_WIDTH  RAM data, valid one cycle after RAM_RD_EN
//   RD_DATA        out  C_WIDTH  head word of the output buffer
//   RD_DATA_VALID  out  head word valid
//   RD_EN          in   consumer takes the head word when RD_DATA_VALID
//
// C_DEPTH_BITS must be below GRAY_MAX_W and must match the comparator.
// ---------------------------------------------------------------------------
module async_fifo_rd_ctrl
  import async_fifo_pkg::*;
#(
  parameter int C_WIDTH      = 32,
  parameter int C_DEPTH_BITS = 10
) (
  input  logic                    RD_CLK,
  input  logic                    RD_RST,
  input  logic                    RD_EMPTY,
  output logic                    RD_VALID,
  output logic [C_DEPTH_BITS-1:0] RD_PTR,
  output logic [C_DEPTH_BITS-1:0] RD_PTR_P1,
  output logic                    RAM_RD_EN,
  output logic [C_DEPTH_BITS-1:0] RAM_RD_ADDR,
  input  logic [C_WIDTH-1:0]      RAM_RD_DATA,
  output logic [C_WIDTH-1:0]      RD_DATA,
  output logic                    RD_DATA_VALID,
  input  logic                    RD_EN
);

  logic [C_DEPTH_BITS-1:0] rBin;
  logic                    rInflight;
  logic [1:0]              rOcc;
  logic [C_DEPTH_BITS-1:0] wBinP1;
  logic [2:0]              wPending;
  logic                    wTake;
  logic                    wPop;
  ptr_word_t               wGray;
  ptr_word_t               wGrayP1;
  logic [2*(GRAY_MAX_W-C_DEPTH_BITS)-1:0] unusedGrayHi;

  // Words already committed to the buffer: those sitting in it plus the
  // one the RAM is returning this cycle.
  assign wPending = {1'b0, rOcc} + {2'b00, rInflight};

  assign wTake    = RD_EN & RD_DATA_VALID;

  // Request a word only while the buffer is guaranteed a free slot for it
  // when it arrives; a take this cycle frees one. RD_EMPTY is deliberately
  // kept out of this term because the comparator feeds RD_VALID back into
  // its own EMPTY logic.
  assign RD_VALID = (wPending < 3'd2) | wTake;

  assign wPop        = RD_VALID & ~RD_EMPTY;
  assign RAM_RD_EN   = wPop;
  assign RAM_RD_ADDR = rBin;

  assign wBinP1 = rBin + C_DEPTH_BITS'(1);

  // Read counter and RAM-latency tracker. The counter wraps naturally at
  // 2^C_DEPTH_BITS. rInflight marks that RAM_RD_DATA carries a real word
  // this cycle; clearing it on reset discards a word still in the RAM pipe.
  always_ff @(posedge RD_CLK) begin
    if (RD_RST) begin
      rBin      <= '0;
      rInflight <= 1'b0;
    end else begin
      if (wPop) begin
        rBin <= wBinP1;
      end
      rInflight <= wPop;
    end
  end

  // Both Gray pointers come from the registered counter only, so they are
  // glitch-free for the comparator's synchronisers.
  assign wGray        = bin2gray(ptr_word_t'(rBin));
  assign wGrayP1      = bin2gray(ptr_word_t'(wBinP1));
  assign RD_PTR       = wGray[C_DEPTH_BITS-1:0];
  assign RD_PTR_P1    = wGrayP1[C_DEPTH_BITS-1:0];
  assign unusedGrayHi = {wGray[GRAY_MAX_W-1:C_DEPTH_BITS],
                         wGrayP1[GRAY_MAX_W-1:C_DEPTH_BITS]};

  async_fifo_rd_obuf #(
    .C_WIDTH (C_WIDTH)
  ) u_obuf (
    .RD_CLK    (RD_CLK),
    .RD_RST    (RD_RST),
    .push      (rInflight),
    .push_data (RAM_RD_DATA),
    .take      (wTake),
    .head_data (RD_DATA),
    .occ       (rOcc)
  );

  assign RD_DATA_VALID = (rOcc != 2'd0);

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_async_fifo_rd_ctrl
// Self-checking bench for the FIFO read-side controller. A queue-based
// model of the read side predicts every output on every cycle; directed
// phases add hand-computed literal expectations, then a long randomised
// phase exercises stalls, empties, wrap-around and mid-stream resets.
// ---------------------------------------------------------------------------
module tb_async_fifo_rd_ctrl;

  localparam int W     = 32;
  localparam int DB    = 3;
  localparam int DEPTH = 1 << DB;

  logic          RD_CLK = 1'b0;
  logic          RD_RST;
  logic          RD_EMPTY;
  logic          RD_VALID;
  logic [DB-1:0] RD_PTR;
  logic [DB-1:0] RD_PTR_P1;
  logic          RAM_RD_EN;
  logic [DB-1:0] RAM_RD_ADDR;
  logic [W-1:0]  RAM_RD_DATA = '0;
  logic [W-1:0]  RD_DATA;
  logic          RD_DATA_VALID;
  logic          RD_EN;

  int compCount = 0;
  int failCount = 0;

  // RAM content: in directed phases each address returns itself; in the
  // random phase it returns a word that is refreshed after every read, the
  // way a writer would refill a drained slot.
  logic [W-1:0] mem [DEPTH] = '{default: '0};
  bit           ramScramble = 1'b0;

  async_fifo_rd_ctrl #(
    .C_WIDTH      (W),
    .C_DEPTH_BITS (DB)
  ) dut (
    .RD_CLK        (RD_CLK),
    .RD_RST        (RD_RST),
    .RD_EMPTY      (RD_EMPTY),
    .RD_VALID      (RD_VALID),
    .RD_PTR        (RD_PTR),
    .RD_PTR_P1     (RD_PTR_P1),
    .RAM_RD_EN     (RAM_RD_EN),
    .RAM_RD_ADDR   (RAM_RD_ADDR),
    .RAM_RD_DATA   (RAM_RD_DATA),
    .RD_DATA       (RD_DATA),
    .RD_DATA_VALID (RD_DATA_VALID),
    .RD_EN         (RD_EN)
  );

  always #5 RD_CLK = ~RD_CLK;

  // Dual-port RAM read port: one cycle of latency.
  always @(posedge RD_CLK) begin
    if (RAM_RD_EN) begin
      RAM_RD_DATA      <= ramScramble ? mem[RAM_RD_ADDR] : W'(RAM_RD_ADDR);
      mem[RAM_RD_ADDR] <= $urandom;
    end
  end

  function automatic int grayOf(input int b);
    return (b ^ (b >> 1)) % DEPTH;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h",
               name, $time, actual, expected);
    end
  endtask

  // Drives one cycle's inputs just after the rising edge and returns at
  // the following falling edge, where outputs are settled.
  task automatic applyStimulus(input logic rst, input logic en,
                               input logic empty);
    @(posedge RD_CLK);
    #1;
    RD_RST   = rst;
    RD_EN    = en;
    RD_EMPTY = empty;
    @(negedge RD_CLK);
  endtask

  // -------------------------------------------------------------------------
  // Reference model: words are tracked as a queue of buffered values plus
  // at most one word returning from the RAM. Outputs are checked every
  // falling edge, then the model advances to the state after the next
  // rising edge using the inputs that edge will sample.
  // -------------------------------------------------------------------------
  bit           mValid = 1'b0;
  int           mBin;
  bit           mInfl;
  logic [W-1:0] mInflData;
  logic [W-1:0] mBuf [$];
  logic [W-1:0] mLast;
  int           outstanding;

  always @(negedge RD_CLK) begin
    bit           expDv;
    bit           expTake;
    bit           expRv;
    bit           expPop;
    logic [W-1:0] expData;
    if (mValid) begin
      expDv   = (mBuf.size() != 0);
      expTake = RD_EN && expDv;
      expRv   = ((mBuf.size() + int'(mInfl)) < 2) || expTake;
      expPop  = expRv && !RD_EMPTY;
      expData = expDv ? mBuf[0] : mLast;
      checkOutput("RD_VALID", 32'(RD_VALID), 32'(expRv));
      checkOutput("RAM_RD_EN", 32'(RAM_RD_EN), 32'(expPop));
      checkOutput("RAM_RD_ADDR", 32'(RAM_RD_ADDR), 32'(mBin));
      checkOutput("RD_PTR", 32'(RD_PTR), 32'(grayOf(mBin)));
      checkOutput("RD_PTR_P1", 32'(RD_PTR_P1), 32'(grayOf((mBin + 1) % DEPTH)));
      checkOutput("RD_DATA_VALID", 32'(RD_DATA_VALID), 32'(expDv));
      checkOutput("RD_DATA", RD_DATA, expData);
      checkOutput("pop_while_empty", 32'(RAM_RD_EN && RD_EMPTY), 32'd0);
      if (!RD_RST) begin
        outstanding = outstanding + int'(RAM_RD_EN) - int'(RD_EN && RD_DATA_VALID);
        checkOutput("outstanding_le_2", 32'(outstanding <= 2), 32'd1);
      end
    end
    if (RD_RST === 1'b1) begin
      mValid      = 1'b1;
      mBin        = 0;
      mInfl       = 1'b0;
      mInflData   = '0;
      mBuf.delete();
      mLast       = '0;
      outstanding = 0;
    end else if (mValid) begin
      if (expTake) void'(mBuf.pop_front());
      if (mInfl) mBuf.push_back(mInflData);
      mInfl     = expPop;
      mInflData = ramScramble ? mem[mBin] : W'(mBin);
      if (expPop) mBin = (mBin + 1) % DEPTH;
      if (mBuf.size() != 0) mLast = mBuf[0];
    end
  end

  // -------------------------------------------------------------------------
  // Directed phases followed by randomised traffic.
  // -------------------------------------------------------------------------
  initial begin
    int ptrTab [DEPTH];
    int pops;
    RD_RST   = 1'b1;
    RD_EN    = 1'b0;
    RD_EMPTY = 1'b1;
    ptrTab   = '{0, 1, 3, 2, 6, 7, 5, 4};

    // Reset, then empty for 10 cycles: nothing is read.
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("idle_RAM_RD_EN", 32'(RAM_RD_EN), 32'd0);
      checkOutput("idle_RD_PTR", 32'(RD_PTR), 32'd0);
      checkOutput("idle_RD_PTR_P1", 32'(RD_PTR_P1), 32'd1);
      checkOutput("idle_RD_DATA_VALID", 32'(RD_DATA_VALID), 32'd0);
      checkOutput("idle_RD_VALID", 32'(RD_VALID), 32'd1);
      if (c == 0) checkOutput("idle_RD_DATA", RD_DATA, 32'd0);
    end

    // Empty falls at cycle 5: first word visible at cycle 7, then 1, 2, 3.
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int c = 0; c <= 10; c++) begin
      applyStimulus(1'b0, 1'b1, (c < 5) ? 1'b1 : 1'b0);
      if (c == 6) begin
        checkOutput("latency_dv_c6", 32'(RD_DATA_VALID), 32'd0);
        checkOutput("latency_ptr_c6", 32'(RD_PTR), 32'd1);
      end
      if (c >= 7) begin
        checkOutput("stream_dv", 32'(RD_DATA_VALID), 32'd1);
        checkOutput("stream_data", RD_DATA, 32'(c - 7));
      end
    end

    // Consumer stalled, FIFO not empty: exactly two reads, then no request.
    applyStimulus(1'b1, 1'b0, 1'b1);
    pops = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      pops += int'(RAM_RD_EN);
    end
    checkOutput("stall_pops", 32'(pops), 32'd2);
    checkOutput("stall_rd_valid", 32'(RD_VALID), 32'd0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("resume_dv", 32'(RD_DATA_VALID), 32'd1);
      checkOutput("resume_data", RD_DATA, 32'(c));
    end

    // Continuous reads through two wraps of the 3-bit counter.
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("wrap_ptr", 32'(RD_PTR), 32'(ptrTab[c % DEPTH]));
      checkOutput("wrap_addr", 32'(RAM_RD_ADDR), 32'(c % DEPTH));
      if (c == 7) begin
        checkOutput("wrap_ptr_msb", 32'(RD_PTR), 32'd4);
        checkOutput("wrap_ptr_p1_zero", 32'(RD_PTR_P1), 32'd0);
      end
    end

    // Reset one cycle after a read issued with one word buffered.
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("midrst_pop", 32'(RAM_RD_EN), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("midrst_dv", 32'(RD_DATA_VALID), 32'd0);
      if (c == 0) begin
        checkOutput("midrst_ptr", 32'(RD_PTR), 32'd0);
        checkOutput("midrst_data", RD_DATA, 32'd0);
      end
    end

    // Random traffic with changing bias, rare resets and scrambled RAM.
    ramScramble = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      int  phase;
      bit  en;
      bit  empty;
      bit  rst;
      phase = (c / 500) % 4;
      case (phase)
        0:       begin en = 1'b1;                      empty = ($urandom_range(0, 9) == 0); end
        1:       begin en = ($urandom_range(0, 3) == 0); empty = ($urandom_range(0, 1) == 0); end
        2:       begin en = ($urandom_range(0, 1) == 0); empty = ($urandom_range(0, 3) == 0); end
        default: begin en = ($urandom_range(0, 3) != 0); empty = ($urandom_range(0, 3) != 0); end
      endcase
      rst = ($urandom_range(0, 799) == 0);
      applyStimulus(rst, en, empty);
    end

    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             compCount, failCount);
    $finish;
  end

endmodule

// File: doc/async_fifo_rd_ctrl.md
# async_fifo_rd_ctrl

Read-side controller of the asynchronous FIFO; sits directly upstream of the full/empty comparator on the read clock domain. Owns the binary read counter, drives the Gray-coded `RD_PTR` / `RD_PTR_P1` and the read-request strobe `RD_VALID` into the comparator, and issues reads to the dual-port RAM. Returns RAM data to the consumer through a 2-entry first-word-fall-through output buffer with a valid/enable handshake.

## Interface
- `C_WIDTH`, 32, data word width.
- `C_DEPTH_BITS`, 10, RAM address width; FIFO depth = 2^C_DEPTH_BITS; must match the comparator.
- `RD_CLK`  in  1  read-domain clock; all logic on rising edge.
- `RD_RST`  in  1  synchronous, active-high reset.
- `RD_EMPTY`  in  1  EMPTY from comparator.
- `RD_VALID`  out  1  read request to comparator.
- `RD_PTR`  out  C_DEPTH_BITS  Gray code of read counter.
- `RD_PTR_P1`  out  C_DEPTH_BITS  Gray code of read counter + 1.
- `RAM_RD_EN`  out  1  RAM read enable.
- `RAM_RD_ADDR`  out  C_DEPTH_BITS  binary RAM read address.
- `RAM_RD_DATA`  in  C_WIDTH  RAM read data; valid exactly 1 cycle after `RAM_RD_EN`.
- `RD_DATA`  out  C_WIDTH  head word of output buffer.
- `RD_DATA_VALID`  out  1  head word valid.
- `RD_EN`  in  1  consumer takes head word when `RD_EN & RD_DATA_VALID`.

## Operation
- State: `rBin` (C_DEPTH_BITS), `rInflight` (1 bit, RAM read issued last cycle), `rOcc` (0..2, buffer occupancy).
- `take = RD_EN & RD_DATA_VALID`.
- `RD_VALID = ((rOcc + rInflight) < 2) | take`. Must not depend on `RD_EMPTY` combinationally; the comparator uses `RD_VALID` in its own EMPTY path, so a dependency would form a loop.
- `pop = RD_VALID & ~RD_EMPTY`. `RAM_RD_EN = pop`, `RAM_RD_ADDR = rBin`.
- On `pop`: `rBin <= rBin + 1`, modulo 2^C_DEPTH_BITS.
- `RD_PTR = bin2gray(rBin)`, `RD_PTR_P1 = bin2gray(rBin + 1)`, both from registered `rBin`.
- Wrap: `rBin` = all-ones gives `RD_PTR` = MSB-only and `RD_PTR_P1` = 0. Pop then gives `rBin` = 0.
- `rInflight <= pop`.
- When `rInflight` is set, `RAM_RD_DATA` is written to the buffer tail.
- `rOcc <= rOcc + rInflight - take`. The invariant `rOcc + rInflight <= 2` always holds, so the buffer never overflows.
- Buffer order is strict FIFO.
  - Arrival with `rOcc=0`: goes to head.
  - Arrival with `rOcc=1` and `take`: goes to head.
  - Arrival with `rOcc=1` and no `take`: goes to second slot.
  - Arrival with `rOcc=2`: impossible by invariant.
- `RD_DATA_VALID = (rOcc != 0)`.
- `RD_DATA` holds its value while valid and not taken; it is don't-care when invalid but held at last value.
- `RD_EN` while `RD_DATA_VALID=0` is ignored.
- Reset: `rBin=0`, `rInflight=0`, `rOcc=0`, buffer data 0.
  - Outputs after reset: `RD_PTR=0`, `RD_PTR_P1=1`, `RD_DATA_VALID=0`, `RD_DATA=0`, `RAM_RD_EN=0`.
  - `RD_VALID` after reset = 1 (request asserted, no pop while empty).
- Reset mid-operation: any in-flight RAM word and buffered words are discarded, with no `RD_DATA_VALID` pulse afterwards. The write side must be reset in the same interval.

## Timing
- Pop in cycle t: RAM data at t+1, `RD_DATA_VALID` first high at t+2. This is the empty-to-first-word latency.
- Steady state, comparator not empty, `RD_EN` held high: one word per cycle, `rOcc=1`, `rInflight=1`.
- `RD_EN` low with data pending: at most 2 pops after the stall begins, then `RD_VALID=0` until `take`.
- Pointer update is visible on `RD_PTR` in cycle t+1 after a pop in cycle t.
- No combinational path from `RD_EMPTY` to `RD_VALID`. Paths from `RD_EN` to `RD_VALID` / `RAM_RD_EN` are permitted.

## Structure
- Package `async_fifo_pkg`: `bin2gray` function, shared with the write-side controller.
- Sub-module `async_fifo_rd_obuf`: 2-entry FWFT buffer. Ports: push, push data, take, head data, occupancy.
- Top holds `rBin`, `rInflight`, request/pop logic and Gray conversion.

## Test plan
- Reset then `RD_EMPTY=1` for 10 cycles -> `RAM_RD_EN=0`, `RD_PTR=0`, `RD_PTR_P1=1`, `RD_DATA_VALID=0` throughout.
- `RD_EMPTY` falls at cycle 5, RAM model returns address as data, `RD_EN=1` -> `RD_DATA_VALID` rises at cycle 7 with `RD_DATA=0`, followed by 1, 2, 3 on consecutive cycles.
- `RD_EN=0`, not empty -> exactly 2 pops, then `RD_VALID=0`. `RD_EN=1` resumes with data 0, 1, 2 in order and no loss or duplication.
- `C_DEPTH_BITS=3`, 20 continuous pops -> `RD_PTR` sequence 0, 1, 3, 2, 6, 7, 5, 4, 0, ...; `RAM_RD_ADDR` wraps 7 -> 0.
- `RD_RST` asserted 1 cycle after a pop with `rOcc=1` -> next cycle `RD_DATA_VALID=0`, `RD_PTR=0`, and the in-flight word never appears.
- Random `RD_EN` and `RD_EMPTY` for 10k cycles against a scoreboard -> in-order data, `rOcc + rInflight <= 2` always, and a pop occurs only when `RD_EMPTY=0`.
